// File: rtl/ese507_pkg.sv
// ---------------------------------------------------------------
// ese507_pkg : shared defaults and sizing helpers   | rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package ese507_pkg;

  localparam int OUTW_DEFAULT        = 24;
  localparam int OFIFO_DEPTH_DEFAULT = 19;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ram_2p.sv
// ---------------------------------------------------------------
// fifo_ram_2p : 1W/1R RAM, registered read, write bypass | rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module fifo_ram_2p #(
  parameter int WIDTH = 25,
  parameter int SIZE  = 19,
  localparam int AW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [SIZE];
  logic [WIDTH-1:0] r_rdata;

  // A read of the address being written returns the new word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_we && (i_waddr == i_raddr)) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/fifo_out_flex.sv
// ---------------------------------------------------------------
// fifo_out_flex : FWFT AXI-Stream output FIFO with flags | rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module fifo_out_flex
  import ese507_pkg::*;
#(
  parameter int OUTW      = OUTW_DEFAULT,
  parameter int DEPTH     = OFIFO_DEPTH_DEFAULT,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  localparam int CNTW     = cnt_width(DEPTH),
  localparam int LOGDEPTH = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [OUTW-1:0] IN_AXIS_TDATA,
  input  logic            IN_AXIS_TLAST,
  input  logic            IN_AXIS_TVALID,
  output logic            IN_AXIS_TREADY,
  output logic [OUTW-1:0] OUT_AXIS_TDATA,
  output logic            OUT_AXIS_TLAST,
  output logic            OUT_AXIS_TVALID,
  input  logic            OUT_AXIS_TREADY,
  output logic [CNTW-1:0] count,
  output logic            almost_full,
  output logic            almost_empty
);

  localparam logic [CNTW-1:0]     DEPTH_C  = CNTW'(DEPTH);
  localparam logic [CNTW-1:0]     AF_C     = CNTW'(AF_THRESH);
  localparam logic [CNTW-1:0]     AE_C     = CNTW'(AE_THRESH);
  localparam logic [LOGDEPTH-1:0] LAST_PTR = LOGDEPTH'(DEPTH - 1);

  logic [LOGDEPTH-1:0] r_wr_ptr;
  logic [LOGDEPTH-1:0] r_rd_ptr;
  logic [CNTW-1:0]     r_count;
  logic [LOGDEPTH-1:0] w_raddr;
  logic [OUTW:0]       w_ram_rdata;
  logic                w_wr;
  logic                w_rd;

  // Explicit wrap so non-power-of-two depths never index past the end.
  function automatic logic [LOGDEPTH-1:0] ptr_inc(input logic [LOGDEPTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + LOGDEPTH'(1);
  endfunction

  assign IN_AXIS_TREADY  = (r_count < DEPTH_C) & ~reset & ~flush;
  assign OUT_AXIS_TVALID = (r_count != '0);
  assign w_wr            = IN_AXIS_TVALID & IN_AXIS_TREADY;
  assign w_rd            = OUT_AXIS_TVALID & OUT_AXIS_TREADY;

  // Look ahead on a pop so the next head is registered on the same edge.
  assign w_raddr = w_rd ? ptr_inc(r_rd_ptr) : r_rd_ptr;

  fifo_ram_2p #(
    .WIDTH (OUTW + 1),
    .SIZE  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr),
    .i_wdata ({IN_AXIS_TLAST, IN_AXIS_TDATA}),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_rd) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign OUT_AXIS_TDATA = w_ram_rdata[OUTW-1:0];
  assign OUT_AXIS_TLAST = w_ram_rdata[OUTW];
  assign count          = r_count;
  assign almost_full    = (r_count >= AF_C);
  assign almost_empty   = (r_count <= AE_C);

endmodule

`default_nettype wire

// File: tb/tb_fifo_out_flex.sv
// ---------------------------------------------------------------
// tb_fifo_out_flex : bench for fifo_out_flex (DEPTH 19 and 5) | rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_fifo_out_flex;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [23:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic [23:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic [4:0]  cnt;
  logic        af;
  logic        ae;

  logic        f5 = 1'b0;
  logic [23:0] d5 = '0;
  logic        l5 = 1'b0;
  logic        v5 = 1'b0;
  logic        r5 = 1'b0;
  logic        in_ready5;
  logic [23:0] out_data5;
  logic        out_last5;
  logic        out_valid5;
  logic [2:0]  cnt5;
  logic        af5;
  logic        ae5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fifo_out_flex #(.OUTW(24), .DEPTH(19), .AF_THRESH(17), .AE_THRESH(1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .IN_AXIS_TDATA(in_data), .IN_AXIS_TLAST(in_last),
    .IN_AXIS_TVALID(in_valid), .IN_AXIS_TREADY(in_ready),
    .OUT_AXIS_TDATA(out_data), .OUT_AXIS_TLAST(out_last),
    .OUT_AXIS_TVALID(out_valid), .OUT_AXIS_TREADY(out_ready),
    .count(cnt), .almost_full(af), .almost_empty(ae)
  );

  fifo_out_flex #(.OUTW(24), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(1)) u_dut5 (
    .clk(clk), .reset(reset), .flush(f5),
    .IN_AXIS_TDATA(d5), .IN_AXIS_TLAST(l5),
    .IN_AXIS_TVALID(v5), .IN_AXIS_TREADY(in_ready5),
    .OUT_AXIS_TDATA(out_data5), .OUT_AXIS_TLAST(out_last5),
    .OUT_AXIS_TVALID(out_valid5), .OUT_AXIS_TREADY(r5),
    .count(cnt5), .almost_full(af5), .almost_empty(ae5)
  );

  typedef struct {
    logic        v;
    logic [23:0] d;
    logic        l;
    logic        r;
    logic        f;
    int          cnt;
    logic        tv;
    logic [23:0] hd;
    logic        hl;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [8];
    logic [24:0] q5 [$];
    int sz;
    logic ewr, erd;
    logic [23:0] exp_d;

    tbl[0] = '{1'b1, 24'hABCDEF, 1'b1, 1'b0, 1'b0, 1, 1'b1, 24'hABCDEF, 1'b1};
    tbl[1] = '{1'b1, 24'h000111, 1'b0, 1'b0, 1'b0, 2, 1'b1, 24'hABCDEF, 1'b1};
    tbl[2] = '{1'b1, 24'h000222, 1'b0, 1'b1, 1'b0, 2, 1'b1, 24'h000111, 1'b0};
    tbl[3] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1, 1'b1, 24'h000222, 1'b0};
    tbl[4] = '{1'b1, 24'h000333, 1'b1, 1'b1, 1'b0, 1, 1'b1, 24'h000333, 1'b1};
    tbl[5] = '{1'b1, 24'h000444, 1'b0, 1'b1, 1'b1, 0, 1'b0, 24'h000000, 1'b0};
    tbl[6] = '{1'b1, 24'h000555, 1'b1, 1'b0, 1'b0, 1, 1'b1, 24'h000555, 1'b1};
    tbl[7] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 0, 1'b0, 24'h000000, 1'b0};

    // Reset state
    #2;
    chk("rst_count", 32'(cnt), 0);
    chk("rst_tvalid", 32'(out_valid), 0);
    chk("rst_tready", 32'(in_ready), 0);
    chk("rst_ae", 32'(ae), 1);
    chk("rst_af", 32'(af), 0);
    #10 reset = 1'b0;
    tick();
    chk("post_rst_tready", 32'(in_ready), 1);

    // Table: fall-through, head replacement at count 1, flush
    for (int i = 0; i < 8; i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; in_last = tbl[i].l;
      out_ready = tbl[i].r; flush = tbl[i].f;
      tick();
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      chk($sformatf("tbl%0d_count", i), 32'(cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_tvalid", i), 32'(out_valid), 32'(tbl[i].tv));
      if (tbl[i].tv) begin
        chk($sformatf("tbl%0d_tdata", i), 32'(out_data), 32'(tbl[i].hd));
        chk($sformatf("tbl%0d_tlast", i), 32'(out_last), 32'(tbl[i].hl));
      end
    end

    // Fill to full then drain in order
    in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 19; i++) begin
      in_data = 24'(i);
      #1 chk("fill_tready", 32'(in_ready), 1);
      tick();
      chk("fill_count", 32'(cnt), 32'(i + 1));
      chk("fill_af", 32'(af), 32'((i + 1) >= 17));
      chk("fill_ae", 32'(ae), 32'((i + 1) <= 1));
    end
    #1 chk("full_tready", 32'(in_ready), 0);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      #1;
      chk("drain_tvalid", 32'(out_valid), 1);
      chk("drain_tdata", 32'(out_data), 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_end_tvalid", 32'(out_valid), 0);
    chk("drain_end_count", 32'(cnt), 0);

    // Full with a simultaneous read: the write must wait a cycle
    in_valid = 1'b1;
    for (int i = 0; i < 19; i++) begin
      in_data = 24'(100 + i);
      tick();
    end
    in_data = 24'h999; out_ready = 1'b1;
    #1 chk("fullrd_tready", 32'(in_ready), 0);
    tick();
    chk("fullrd_count", 32'(cnt), 18);
    out_ready = 1'b0;
    #1 chk("fullrd_tready2", 32'(in_ready), 1);
    tick();
    chk("fullrd_count2", 32'(cnt), 19);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      exp_d = (i < 18) ? 24'(101 + i) : 24'h999;
      #1 chk("fullrd_tdata", 32'(out_data), 32'(exp_d));
      tick();
    end
    out_ready = 1'b0;
    chk("fullrd_end_count", 32'(cnt), 0);

    // Streaming at count 1 with no bubbles
    in_valid = 1'b1; in_data = 24'd1;
    tick();
    out_ready = 1'b1;
    for (int i = 2; i <= 101; i++) begin
      in_data = 24'(i);
      #1;
      chk("stream_tdata", 32'(out_data), 32'(i - 1));
      chk("stream_count", 32'(cnt), 1);
      tick();
    end
    in_valid = 1'b0;
    #1 chk("stream_last", 32'(out_data), 101);
    tick();
    out_ready = 1'b0;
    chk("stream_end_count", 32'(cnt), 0);

    // Flush at count 7 with write and read both active
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = 24'(200 + i);
      tick();
    end
    chk("pre_flush_count", 32'(cnt), 7);
    in_data = 24'h666; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", 32'(cnt), 0);
    chk("flush_tvalid", 32'(out_valid), 0);
    in_valid = 1'b1; in_data = 24'h000077;
    tick();
    in_valid = 1'b0;
    chk("post_flush_tvalid", 32'(out_valid), 1);
    chk("post_flush_tdata", 32'(out_data), 32'h77);
    chk("post_flush_count", 32'(cnt), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_flush_drain", 32'(cnt), 0);

    // Asynchronous reset between edges
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 24'(300 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_arst_count", 32'(cnt), 3);
    #3 reset = 1'b1;
    #1;
    chk("arst_count", 32'(cnt), 0);
    chk("arst_tvalid", 32'(out_valid), 0);
    chk("arst_tready", 32'(in_ready), 0);
    chk("arst_ae", 32'(ae), 1);
    chk("arst_af", 32'(af), 0);
    #2 reset = 1'b0;
    tick();
    chk("post_arst_tready", 32'(in_ready), 1);
    chk("post_arst_count", 32'(cnt), 0);

    // Randomised traffic on the DEPTH=5 instance against a queue model
    for (int c = 0; c < 400; c++) begin
      v5 = ($urandom_range(0, 2) != 0);
      r5 = $urandom_range(0, 1) != 0;
      f5 = ($urandom_range(0, 39) == 0);
      d5 = 24'($urandom);
      l5 = $urandom_range(0, 1) != 0;
      #1;
      sz = q5.size();
      chk("rnd_count", 32'(cnt5), 32'(sz));
      chk("rnd_tvalid", 32'(out_valid5), 32'(sz != 0));
      chk("rnd_tready", 32'(in_ready5), 32'((sz < 5) && !f5));
      chk("rnd_af", 32'(af5), 32'(sz >= 3));
      chk("rnd_ae", 32'(ae5), 32'(sz <= 1));
      if (sz != 0) begin
        chk("rnd_head", 32'({out_last5, out_data5}), 32'(q5[0]));
      end
      ewr = v5 && (sz < 5) && !f5;
      erd = (sz != 0) && r5;
      tick();
      if (f5) begin
        q5.delete();
      end else begin
        if (erd) void'(q5.pop_front());
        if (ewr) q5.push_back({l5, d5});
      end
    end
    v5 = 1'b0; r5 = 1'b0; f5 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_out_flex.md
Name: fifo_out_flex

Overview:
- Parametrised AXI-Stream output FIFO; successor to the Part 2 output FIFO. Buffers accelerator output words ahead of the external stream sink.
- Adds TLAST sideband storage, a synchronous flush, an occupancy count, programmable almost-full/almost-empty flags, and correct full handling for any DEPTH, including non-powers of two.
- Output is first-word-fall-through: OUT_AXIS_TDATA/TLAST are valid whenever OUT_AXIS_TVALID is 1.

Parameters:
- OUTW, 24, data word width in bits (>=1)
- DEPTH, 19, number of entries (>=2; any integer)
- AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH
- AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH
- CNTW (localparam), $clog2(DEPTH+1), width of count
- LOGDEPTH (localparam), $clog2(DEPTH), pointer width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of contents
- IN_AXIS_TDATA  in  OUTW  write data
- IN_AXIS_TLAST  in  1  end-of-output-tile marker, stored with data
- IN_AXIS_TVALID  in  1  upstream has data
- IN_AXIS_TREADY  out  1  FIFO can accept a word
- OUT_AXIS_TDATA  out  OUTW  head-of-FIFO data
- OUT_AXIS_TLAST  out  1  head-of-FIFO TLAST
- OUT_AXIS_TVALID  out  1  FIFO non-empty
- OUT_AXIS_TREADY  in  1  downstream accepts
- count  out  CNTW  current occupancy, 0..DEPTH
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH

Behaviour:
- Handshakes: wr = IN_TVALID & IN_TREADY; rd = OUT_TVALID & OUT_TREADY.
- IN_AXIS_TREADY = (count < DEPTH) & ~reset & ~flush. It does not depend on OUT_TREADY, so no write is accepted when full, even if a read happens in the same cycle.
- OUT_AXIS_TVALID = (count != 0). Once asserted, TDATA/TLAST stay stable until rd.
- Async reset: count=0, wr_ptr=rd_ptr=0, OUT_TVALID=0, IN_TREADY=0 while reset is high, almost_empty=1 (AE_THRESH>=0), almost_full=0. Memory contents are not reset; OUT_TDATA is don't-care while TVALID=0.
- Flush, sampled at the clock edge: next count=0 and both pointers=0. A wr or rd in the same cycle is discarded. Flush has priority over everything except reset.
- Count update: wr only -> +1; rd only -> -1; both or neither -> unchanged.
- Pointers: each advances by 1 on its handshake and wraps DEPTH-1 -> 0. Non-power-of-2 wrap is explicit.
- Latency: a word written at edge N (FIFO previously empty) is presented with OUT_TVALID=1 in the cycle after edge N. This gives one-cycle fall-through.
- Read address lookahead: the RAM read address is rd_ptr+1 (with wrap) when rd, else rd_ptr. The next head is therefore registered on the same edge as the pop.
- Bypass: if the RAM read address equals the write address on a wr cycle, the RAM output register takes the write data. This covers the empty-write, full-wrap and simultaneous read/write-at-head cases.
- Simultaneous rd+wr with count==1: the new word becomes the head the next cycle, count stays 1, and TVALID stays 1.
- count, almost_full and almost_empty are combinational from the count register. No extra latency.
- TLAST is stored as bit OUTW of a (OUTW+1)-bit RAM word.

Decomposition:
- Shared package (ese507_pkg): default OUTW, default output FIFO DEPTH, and the function for the count width.
- One sub-module, fifo_ram_2p: WIDTH, SIZE; one write port and one registered read port with write-to-read bypass; no reset.
- All control (pointers, count, flags, flush) stays in fifo_out_flex.

Test Plan:
- Reset fill/drain: DEPTH=19, OUT_TREADY=0, write 0..18 -> IN_TREADY drops after the 19th word, count=19, almost_full from count 17. Then OUT_TREADY=1 -> reads 0..18 in order, one per cycle, TVALID falls after the last.
- Full with simultaneous read: at count=19, hold IN_TVALID=1 and OUT_TREADY=1 -> no write that cycle (TREADY=0), count=18 next cycle, then the write is accepted.
- Fall-through: empty FIFO, write 0xABCDEF with TLAST=1 at edge N -> cycle after N shows TVALID=1, TDATA=0xABCDEF, TLAST=1, count=1.
- Streaming at count==1: continuous rd+wr of 1..100 for 100 cycles -> output is the exact sequence, count stays 1, no bubbles.
- Wrap with non-power-of-2: DEPTH=5, push/pop 23 words with random valid/ready (seeded) -> scoreboard match, pointers wrap 4->0.
- Flush and async reset mid-stream: count=7, assert flush with wr and rd high -> next cycle count=0, TVALID=0, and the discarded words never appear. Then reset pulsed between clock edges -> count=0 and TVALID=0 immediately, without waiting for a clock.
